// File: rtl/pxie_cmd_decoder.sv
// pxie_cmd_decoder: decodes 0xEB9C-tagged PXIe header words into command pulses,
// config registers, a readback request and counted RAM write bursts.
module pxie_cmd_decoder #(
  parameter int DATA_W    = 128,
  parameter int N_CH      = 4,
  parameter int ADDR_W    = 32,
  parameter int PULSE_LEN = 50,
  parameter int TIMEOUT   = 1024
) (
  input  logic              I_PXIE_CLK,
  input  logic              I_Rst_n,
  input  logic [DATA_W-1:0] I_PXIE_DATA,
  input  logic              I_PXIE_DATA_VLD,
  output logic              O_Rst,
  output logic              O_Trig,
  output logic              O_Run,
  output logic [31:0]       O_Trig_Num,
  output logic [31:0]       O_Trig_Step,
  output logic [N_CH-1:0]   O_ram_wren,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic [DATA_W-1:0] O_ram_data,
  output logic [15:0]       O_c2h_addr,
  output logic [15:0]       O_c2h_len,
  output logic              O_c2h_en,
  output logic              O_busy,
  output logic [15:0]       O_err_cnt
);
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_BURST} state_t;
  state_t state_q;
  logic [7:0] pcnt_q;
  logic [15:0] tcnt_q, bcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] ch_q;
  logic [15:0] op, cnt, err_d;
  logic [31:0] arg;
  logic is_hdr, is_pulse, is_wr;
  assign op = I_PXIE_DATA[15:0];
  assign cnt = I_PXIE_DATA[47:32];
  assign arg = I_PXIE_DATA[127:96];
  assign is_hdr = I_PXIE_DATA_VLD && I_PXIE_DATA[63:48] == 16'hEB9C;
  assign is_pulse = op == 16'h0001 || op == 16'h0002 || op == 16'h0005;
  assign is_wr = op[15:4] == 12'h200 && {1'b0, op[3:0]} < 5'(N_CH) && cnt != 16'd0;
  assign err_d = O_err_cnt + {15'd0, O_err_cnt != 16'hFFFF};
  assign O_busy = state_q != ST_IDLE;
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n)
    if (!I_Rst_n) begin
      state_q <= ST_IDLE;
      pcnt_q <= '0;
      tcnt_q <= '0;
      bcnt_q <= '0;
      addr_q <= '0;
      ch_q <= '0;
      O_Rst <= 1'b0;
      O_Trig <= 1'b0;
      O_Run <= 1'b0;
      O_Trig_Num <= '0;
      O_Trig_Step <= '0;
      O_ram_wren <= '0;
      O_ram_addr <= '0;
      O_ram_data <= '0;
      O_c2h_addr <= '0;
      O_c2h_len <= '0;
      O_c2h_en <= 1'b0;
      O_err_cnt <= '0;
    end else begin
      O_ram_wren <= '0;
      O_c2h_en <= 1'b0;
      case (state_q)
        ST_IDLE:
          if (is_hdr) begin
            if (is_pulse) begin
              state_q <= ST_PULSE;
              pcnt_q <= 8'(PULSE_LEN - 1);
              O_Rst <= op == 16'h0001;
              O_Trig <= op == 16'h0002;
              O_Run <= op == 16'h0005;
            end else if (op == 16'h0003) O_Trig_Num <= arg;
            else if (op == 16'h0004) O_Trig_Step <= arg;
            else if (op == 16'h1010) begin
              O_c2h_addr <= arg[15:0];
              O_c2h_len <= arg[31:16];
              O_c2h_en <= 1'b1;
            end else if (is_wr) begin
              state_q <= ST_BURST;
              ch_q <= op[3:0];
              bcnt_q <= cnt;
              addr_q <= arg[ADDR_W-1:0];
              tcnt_q <= '0;
            end else O_err_cnt <= err_d;
          end
        ST_PULSE: begin
          if (pcnt_q == 8'd0) begin
            state_q <= ST_IDLE;
            O_Rst <= 1'b0;
            O_Trig <= 1'b0;
            O_Run <= 1'b0;
          end else pcnt_q <= pcnt_q - 8'd1;
          if (is_hdr) O_err_cnt <= err_d;
        end
        ST_BURST:
          // payload words are written raw; the magic tag means nothing here
          if (I_PXIE_DATA_VLD) begin
            O_ram_wren <= N_CH'(1) << ch_q;
            O_ram_addr <= addr_q;
            O_ram_data <= I_PXIE_DATA;
            addr_q <= addr_q + 1'b1;
            bcnt_q <= bcnt_q - 16'd1;
            tcnt_q <= '0;
            if (bcnt_q == 16'd1) state_q <= ST_IDLE;
          end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
            state_q <= ST_IDLE;
            O_err_cnt <= err_d;
          end else tcnt_q <= tcnt_q + 16'd1;
        default: state_q <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_pxie_cmd_decoder.sv
// tb_pxie_cmd_decoder: directed bench; RAM writes are checked against a scoreboard queue.
module tb_pxie_cmd_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [127:0] data = '0;
  logic vld = 1'b0;
  logic o_rst, o_trig, o_run, o_c2h_en, o_busy;
  logic [31:0] o_trig_num, o_trig_step;
  logic [3:0] o_wren;
  logic [15:0] o_addr, o_c2h_addr, o_c2h_len, o_err;
  logic [127:0] o_data;
  typedef struct packed {logic [3:0] w; logic [15:0] a; logic [127:0] d;} wr_t;
  wr_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  pxie_cmd_decoder #(.DATA_W(128), .N_CH(4), .ADDR_W(16), .PULSE_LEN(50), .TIMEOUT(16)) dut (
    .I_PXIE_CLK(clk), .I_Rst_n(rst_n), .I_PXIE_DATA(data), .I_PXIE_DATA_VLD(vld),
    .O_Rst(o_rst), .O_Trig(o_trig), .O_Run(o_run), .O_Trig_Num(o_trig_num), .O_Trig_Step(o_trig_step),
    .O_ram_wren(o_wren), .O_ram_addr(o_addr), .O_ram_data(o_data),
    .O_c2h_addr(o_c2h_addr), .O_c2h_len(o_c2h_len), .O_c2h_en(o_c2h_en),
    .O_busy(o_busy), .O_err_cnt(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] hdr(logic [15:0] op, logic [15:0] cnt, logic [31:0] arg);
    logic [127:0] h = '0;
    h[127:96] = arg;
    h[63:48] = 16'hEB9C;
    h[47:32] = cnt;
    h[15:0] = op;
    return h;
  endfunction

  function automatic logic [127:0] rnd();
    logic [127:0] r = {$urandom, $urandom, $urandom, $urandom};
    r[63:48] = 16'h0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [127:0] d);
    vld = v;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {o_rst, o_trig, o_run, o_trig_num, o_trig_step, o_wren, o_addr, o_c2h_addr,
              o_c2h_len, o_c2h_en, o_busy, o_err}, '0);
    chk(tag, o_data, '0);
  endtask

  task automatic do_reset();
    vld = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_err = 0;
  endtask

  // scoreboard: any write seen must match the oldest expected one
  always @(negedge clk)
    if (rst_n && o_wren !== 4'b0) begin
      wr_t got, exp;
      got = '{o_wren, o_addr, o_data};
      exp = q.size() != 0 ? q.pop_front() : '0;
      checks++;
      assert (got === exp) else begin
        errors++;
        $error("FAIL ram_write got %0h exp %0h", got, exp);
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d, m;
    int bad;
    @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    // reset pulse: 50 cycles high from t+1 with busy
    drive(1'b1, hdr(16'h0001, 16'd0, 32'd0));
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (o_rst !== 1'b1 || o_busy !== 1'b1 || o_trig !== 1'b0 || o_run !== 1'b0) bad++;
      drive(1'b0, '0);
    end
    chk("rst_pulse_bad_cycles", bad, 0);
    chk("rst_pulse_end", {o_rst, o_busy}, 2'b00);
    chk("err_after_pulse", o_err, 0);
    // channel-2 burst wrapping at 0xFFFF
    drive(1'b1, hdr(16'h2002, 16'd3, 32'h0000FFFF));
    chk("burst_busy", o_busy, 1);
    for (int i = 0; i < 3; i++) begin
      d = rnd();
      q.push_back('{4'b0100, 16'(32'hFFFF + i), d});
      drive(1'b1, d);
    end
    chk("burst_done_idle", o_busy, 0);
    drive(1'b1, hdr(16'h0003, 16'd0, 32'h0000AAAA));
    chk("header_after_burst", o_trig_num, 32'hAAAA);
    drive(1'b0, '0);
    // gapped burst whose second payload looks like a reset header
    drive(1'b1, hdr(16'h2003, 16'd2, 32'h00000020));
    d = rnd();
    q.push_back('{4'b1000, 16'h0020, d});
    drive(1'b1, d);
    drive(1'b0, '0);
    drive(1'b0, '0);
    m = hdr(16'h0001, 16'd0, 32'd0);
    q.push_back('{4'b1000, 16'h0021, m});
    drive(1'b1, m);
    chk("gap_burst_idle", o_busy, 0);
    chk("magic_payload_no_rst", o_rst, 0);
    drive(1'b0, '0);
    chk("magic_payload_no_rst2", o_rst, 0);
    // timeout after 2 of 5 words
    drive(1'b1, hdr(16'h2001, 16'd5, 32'h00000100));
    for (int i = 0; i < 2; i++) begin
      d = rnd();
      q.push_back('{4'b0010, 16'(32'h100 + i), d});
      drive(1'b1, d);
    end
    for (int i = 0; i < 15; i++) drive(1'b0, '0);
    chk("timeout_still_busy", o_busy, 1);
    drive(1'b0, '0);
    chk("timeout_idle", o_busy, 0);
    exp_err++;
    chk("timeout_err", o_err, exp_err);
    drive(1'b1, hdr(16'h0003, 16'd0, 32'h00001234));
    chk("trig_num_after_timeout", o_trig_num, 32'h1234);
    drive(1'b1, rnd());
    drive(1'b0, '0);
    chk("idle_noise_no_err", o_err, exp_err);
    // run pulse with a header arriving mid-pulse
    drive(1'b1, hdr(16'h0005, 16'd0, 32'd0));
    chk("run_pulse_start", o_run, 1);
    drive(1'b1, hdr(16'h0002, 16'd0, 32'd0));
    for (int i = 0; i < 48; i++) drive(1'b0, '0);
    chk("run_pulse_last", {o_run, o_trig, o_busy}, 3'b101);
    exp_err++;
    chk("hdr_in_pulse_err", o_err, exp_err);
    drive(1'b0, '0);
    chk("run_pulse_end", {o_run, o_busy}, 2'b00);
    // errors and readback from a clean reset
    do_reset();
    drive(1'b1, hdr(16'h7777, 16'd0, 32'd0));
    drive(1'b1, hdr(16'h2009, 16'd3, 32'd0));
    drive(1'b1, rnd());
    drive(1'b0, '0);
    chk("err_unknown_and_badch", o_err, 2);
    chk("badch_not_busy", o_busy, 0);
    drive(1'b1, hdr(16'h2002, 16'd0, 32'd0));
    drive(1'b1, rnd());
    drive(1'b0, '0);
    chk("err_zero_count", o_err, 3);
    drive(1'b1, hdr(16'h1010, 16'd0, 32'h00400100));
    chk("c2h_req", {o_c2h_addr, o_c2h_len, o_c2h_en}, {16'h0100, 16'h0040, 1'b1});
    drive(1'b0, '0);
    chk("c2h_strobe_one_cycle", {o_c2h_addr, o_c2h_en}, {16'h0100, 1'b0});
    drive(1'b1, hdr(16'h0003, 16'd0, 32'h00005A5A));
    drive(1'b1, hdr(16'h0004, 16'd0, 32'hDEADBEEF));
    chk("trig_step", o_trig_step, 32'hDEADBEEF);
    chk("trig_num_held", o_trig_num, 32'h5A5A);
    // reset asserted during word 2 of a 10-word burst
    drive(1'b1, hdr(16'h2001, 16'd10, 32'h00000010));
    d = rnd();
    q.push_back('{4'b0010, 16'h0010, d});
    drive(1'b1, d);
    data = rnd();
    #6;
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid_burst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, rnd());
    drive(1'b1, rnd());
    drive(1'b0, '0);
    chk("post_reset_idle", {o_busy, o_err}, 17'd0);
    drive(1'b1, hdr(16'h2000, 16'd1, 32'h00000055));
    d = rnd();
    q.push_back('{4'b0001, 16'h0055, d});
    drive(1'b1, d);
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
